// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads to instruction memory,
// fills the IF/ID register one instruction per cycle, and parks a returned
// word in a one-entry skid buffer when decode stalls. Taken branches redirect
// fetch and squash whatever is in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_instr,
  output logic [3:0]  if_opcode,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] skid_instr, skid_instr_next;
  logic [31:0] skid_pc, skid_pc_next;
  logic        skid_valid, skid_valid_next;
  logic [31:0] if_instr_next, if_pc_next;
  logic        if_valid_next;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 rolls over to zero.
  assign pc_plus4    = pc + 32'd4;
  // Low two target bits are dropped so every fetch stays word-aligned.
  assign redirect_pc = branch_target & ~32'h0000_0003;

  // Memory is only asked for data in FETCH; the address is the live pc.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // A bubble carries instr=0, which decodes as the NOP opcode.
  assign if_opcode = if_instr[31:28];

  // Next-state and datapath selection; branch redirect outranks everything.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next      = state;
    pc_next         = pc;
    skid_instr_next = skid_instr;
    skid_pc_next    = skid_pc;
    skid_valid_next = skid_valid;
    if_instr_next   = if_instr;
    if_pc_next      = if_pc;
    if_valid_next   = if_valid;

    if (state != START && branch_taken) begin
      // Squash: drop the skid entry, ignore same-cycle read data, and
      // restart fetching at the target next cycle.
      pc_next         = redirect_pc;
      skid_valid_next = 1'b0;
      if_instr_next   = 32'h0;
      if_valid_next   = 1'b0;
      state_next      = FETCH;
    end else begin
      case (state)
        START: begin
          state_next = FETCH;
        end

        FETCH: begin
          if (imem_ready) begin
            pc_next = pc_plus4;
            if (stall) begin
              // Decode is busy: park the word and stop requesting.
              skid_instr_next = imem_rdata;
              skid_pc_next    = pc;
              skid_valid_next = 1'b1;
              state_next      = HOLD;
            end else begin
              if_instr_next = imem_rdata;
              if_pc_next    = pc;
              if_valid_next = 1'b1;
            end
          end else if (!stall) begin
            // Memory wait: hand decode a bubble, keep if_pc as it was.
            if_instr_next = 32'h0;
            if_valid_next = 1'b0;
          end
        end

        HOLD: begin
          if (!stall) begin
            // Drain the parked word into IF/ID and resume fetching.
            if_instr_next   = skid_instr;
            if_pc_next      = skid_pc;
            if_valid_next   = skid_valid;
            skid_valid_next = 1'b0;
            state_next      = FETCH;
          end
        end

        default: begin
          state_next = START;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= START;
      pc         <= RESET_PC;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      skid_valid <= 1'b0;
      if_instr   <= 32'h0;
      if_pc      <= 32'h0;
      if_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state      <= state_next;
      pc         <= pc_next;
      skid_instr <= skid_instr_next;
      skid_pc    <= skid_pc_next;
      skid_valid <= skid_valid_next;
      if_instr   <= if_instr_next;
      if_pc      <= if_pc_next;
      if_valid   <= if_valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// ready/stall/branch traffic, compared against a queue-based model of the
// fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_instr;
  logic [3:0]  if_opcode;
  logic [31:0] if_pc;
  logic        if_valid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_instr     (if_instr),
    .if_opcode    (if_opcode),
    .if_pc        (if_pc),
    .if_valid     (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instructions fetched but not yet accepted by decode wait in m_q; while
  // anything waits there, nothing new is requested.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];
  logic        m_started;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8000_0000 + a;
  endfunction

  function automatic logic m_req();
    return m_started && (m_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_started = 1'b0;
    m_pc      = RESET_PC;
    m_instr   = 32'h0;
    m_ifpc    = 32'h0;
    m_valid   = 1'b0;
  endtask

  task automatic model_update(input logic rdy, input logic st, input logic br,
                              input logic [31:0] tgt);
    entry_t e;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (br) begin
      m_pc    = {tgt[31:2], 2'b00};
      m_q.delete();
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (m_q.size() != 0) begin
      if (!st) begin
        e       = m_q.pop_front();
        m_instr = e.instr;
        m_ifpc  = e.pc;
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      if (st) begin
        e.instr = mem_word(m_pc);
        e.pc    = m_pc;
        m_q.push_back(e);
      end else begin
        m_instr = mem_word(m_pc);
        m_ifpc  = m_pc;
        m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic step(input logic rdy, input logic st, input logic br,
                      input logic [31:0] tgt);
    imem_ready    = rdy;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_rdata    = rdy ? mem_word(m_pc) : 32'hDEAD_BEEF;
    #1;
    check("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
    if (m_req()) check("imem_addr", imem_addr, m_pc);
    model_update(rdy, st, br, tgt);
    @(posedge clk);
    #1;
    check("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
    check("if_instr", if_instr, m_instr);
    check("if_opcode", {28'h0, if_opcode}, {28'h0, m_instr[31:28]});
    if (m_valid) check("if_pc", if_pc, m_ifpc);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
    check({tag, "_instr"}, if_instr, 32'h0);
    check({tag, "_opcode"}, {28'h0, if_opcode}, 32'h0);
    check({tag, "_pc"}, if_pc, 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    // Ready pulses during reset must leave no trace.
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    check_zero_outputs("reset_hold");
    rst = 1'b0;

    // Always-ready stream from RESET_PC (START cycle first).
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);            // 0x0
    step(1, 0, 0, 0);            // 0x4
    // Two memory wait cycles at 0x8, then it arrives.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);            // 0x8
    // Stall for three cycles while 0xC returns.
    step(1, 1, 0, 0);            // 0xC parked, HOLD
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);            // 0xC delivered
    step(1, 0, 0, 0);            // 0x10 delivered
    // Park 0x14, then branch to 0x103 while still stalled in HOLD.
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0103);
    step(1, 0, 0, 0);            // 0x100
    step(1, 0, 0, 0);            // 0x104
    // Wrap-around at the top of the address space.
    step(1, 0, 1, 32'hFFFF_FFFE);
    step(1, 0, 0, 0);            // 0xFFFF_FFFC
    step(1, 0, 0, 0);            // 0x0
    // Stalled with memory waiting: nothing moves.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);

    // Asynchronous reset mid-cycle while fetching 0x20.
    step(1, 0, 1, 32'h0000_0020);
    imem_ready = 1'b0;
    stall      = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #3;
    imem_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0);            // START
    step(1, 0, 0, 0);            // refetch at RESET_PC
    step(1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 19) == 0);
      t = $urandom();
      if ($urandom_range(0, 49) == 0) t = 32'hFFFF_FFF8 | t[1:0];
      step(r, s, b, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
